// File: rtl/alu_issue_if.sv
// Handshake, ALU and debug signals shared by the issue controller and its environment.
interface alu_issue_if;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    logic [2:0]  aluop;
    logic [7:0]  aluresult;
    logic        zero;
    logic        done;
    logic        illegal;
    logic        zero_flag;
    logic [2:0]  dbg_addr;
    logic [7:0]  dbg_data;

    modport master (
        input  instruction, instr_valid, aluresult, zero, dbg_addr,
        output instr_ready, operand1, operand2, aluop, done, illegal, zero_flag, dbg_data
    );

    modport slave (
        output instruction, instr_valid, aluresult, zero, dbg_addr,
        input  instr_ready, operand1, operand2, aluop, done, illegal, zero_flag, dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: accepts one instruction, reads the register file,
// drives the ALU, waits a fixed settle time and writes the result back.
module alu_issue_ctrl #(
    parameter int unsigned ALU_WAIT  = 1,
    parameter int unsigned MULT_WAIT = 3
) (
    input  logic      clk,
    input  logic      reset,
    alu_issue_if.master bus
);
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned REG_N    = 8;
    localparam int unsigned MAX_WAIT = (MULT_WAIT > ALU_WAIT) ? MULT_WAIT : ALU_WAIT;
    localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic [2:0]          aluop_q, aluop_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                illegal_q, illegal_d;
    logic                zflag_q, zflag_d;
    logic [DATA_W-1:0]   regs_q [REG_N];
    logic                wr_en;

    logic [7:0]          opc;
    logic [2:0]          dest;
    logic [DATA_W-1:0]   src1, src2, imm;

    assign opc  = instr_q[31:24];
    assign dest = instr_q[18:16];
    assign src1 = regs_q[instr_q[10:8]];
    assign src2 = regs_q[instr_q[2:0]];
    assign imm  = instr_q[7:0];

    // Next-state, decode and writeback control.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        aluop_d   = aluop_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        zflag_d   = zflag_q;
        wr_en     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instruction;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(ALU_WAIT - 1);
                unique case (opc)
                    8'h00: begin aluop_d = 3'b000; op2_d = imm; end
                    8'h01: begin aluop_d = 3'b000; op2_d = src2; end
                    8'h02: begin aluop_d = 3'b001; op1_d = src1; op2_d = src2; end
                    8'h03: begin aluop_d = 3'b001; op1_d = src1; op2_d = DATA_W'(~src2 + 8'd1); end
                    8'h04: begin aluop_d = 3'b010; op1_d = src1; op2_d = src2; end
                    8'h05: begin aluop_d = 3'b011; op1_d = src1; op2_d = src2; end
                    8'h06: begin
                        aluop_d = 3'b110; op1_d = src1; op2_d = src2;
                        cnt_d   = CNT_W'(MULT_WAIT - 1);
                    end
                    8'h07: begin aluop_d = 3'b101; op1_d = src1; op2_d = imm; end
                    8'h08: begin aluop_d = 3'b111; op1_d = src1; op2_d = imm; end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                endcase
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    wr_en   = 1'b1;
                    zflag_d = bus.zero;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            aluop_q   <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            zflag_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            aluop_q   <= aluop_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            zflag_q   <= zflag_d;
        end
    end

    // Register file; ALURESULT is only sampled on the final WAIT edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_N); i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[dest] <= bus.aluresult;
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE) & ~reset;
    assign bus.operand1    = op1_q;
    assign bus.operand2    = op2_q;
    assign bus.aluop       = aluop_q;
    assign bus.done        = done_q;
    assign bus.illegal     = illegal_q;
    assign bus.zero_flag   = zflag_q;
    assign bus.dbg_data    = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized self-checking bench for alu_issue_ctrl; the bench also plays the ALU.
module tb_alu_issue_ctrl;
    localparam int unsigned ALU_WAIT  = 1;
    localparam int unsigned MULT_WAIT = 3;

    logic clk = 1'b0;
    logic reset;
    alu_issue_if bus ();

    alu_issue_ctrl #(.ALU_WAIT(ALU_WAIT), .MULT_WAIT(MULT_WAIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU; glitch lets the bench corrupt the result before the sampling edge.
    logic       glitch;
    logic [7:0] glitch_val;
    logic [7:0] alu_calc;
    always_comb begin
        case (bus.aluop)
            3'b000:  alu_calc = bus.operand2;
            3'b001:  alu_calc = bus.operand1 + bus.operand2;
            3'b010:  alu_calc = bus.operand1 & bus.operand2;
            3'b011:  alu_calc = bus.operand1 | bus.operand2;
            3'b110:  alu_calc = bus.operand1 * bus.operand2;
            3'b101:  alu_calc = bus.operand1 << bus.operand2;
            3'b111:  alu_calc = bus.operand1 >> bus.operand2;
            default: alu_calc = 8'h00;
        endcase
    end
    assign bus.aluresult = glitch ? glitch_val : alu_calc;
    assign bus.zero      = (bus.aluresult == 8'h00);

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_reg [8];
    logic [7:0] m_op1, m_op2;
    logic [2:0] m_aluop;
    logic       m_zf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_op1 = 8'h00; m_op2 = 8'h00; m_aluop = 3'b000; m_zf = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 8; i++) begin
            bus.dbg_addr = 3'(i);
            #1;
            check(tag, {24'h0, bus.dbg_data}, {24'h0, m_reg[i]});
        end
    endtask

    // Present instr when ready and return #1 after the accepting edge.
    task automatic accept(input logic [31:0] instr, input logic hold, input logic [31:0] next);
        @(negedge clk);
        check("ready_before_accept", {31'h0, bus.instr_ready}, 32'h1);
        bus.instruction = instr;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) bus.instruction = next;
        else begin
            bus.instr_valid = 1'b0;
            bus.instruction = $urandom;
        end
    endtask

    // Follow an accepted instruction to DONE/ILLEGAL and update the model.
    task automatic observe(input logic [31:0] instr);
        logic [7:0]  op, a, b, imm, res, e_op1, e_op2;
        logic [2:0]  d, e_aluop;
        logic [15:0] prod;
        logic        legal, saw_done, saw_ill;
        int          w, hit;
        op = instr[31:24]; d = instr[18:16]; imm = instr[7:0];
        a = m_reg[instr[10:8]]; b = m_reg[instr[2:0]];
        e_op1 = m_op1; e_op2 = m_op2; e_aluop = m_aluop;
        legal = 1'b1; w = int'(ALU_WAIT); res = 8'h00;
        prod = 16'(a) * 16'(b);
        case (op)
            8'h00: begin e_aluop = 3'b000; e_op2 = imm; res = imm; end
            8'h01: begin e_aluop = 3'b000; e_op2 = b; res = b; end
            8'h02: begin e_aluop = 3'b001; e_op1 = a; e_op2 = b; res = 8'((int'(a) + int'(b)) % 256); end
            8'h03: begin e_aluop = 3'b001; e_op1 = a; e_op2 = 8'((256 - int'(b)) % 256);
                         res = 8'((int'(a) - int'(b) + 256) % 256); end
            8'h04: begin e_aluop = 3'b010; e_op1 = a; e_op2 = b; res = a & b; end
            8'h05: begin e_aluop = 3'b011; e_op1 = a; e_op2 = b; res = a | b; end
            8'h06: begin e_aluop = 3'b110; e_op1 = a; e_op2 = b; res = prod[7:0]; w = int'(MULT_WAIT); end
            8'h07: begin e_aluop = 3'b101; e_op1 = a; e_op2 = imm;
                         res = (imm > 8'd7) ? 8'h00 : 8'((int'(a) * (1 << imm)) % 256); end
            8'h08: begin e_aluop = 3'b111; e_op1 = a; e_op2 = imm;
                         res = (imm > 8'd7) ? 8'h00 : 8'(int'(a) / (1 << imm)); end
            default: legal = 1'b0;
        endcase
        hit = 0; saw_done = 1'b0; saw_ill = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                check("aluop", {29'h0, bus.aluop}, {29'h0, e_aluop});
                check("operand1", {24'h0, bus.operand1}, {24'h0, e_op1});
                check("operand2", {24'h0, bus.operand2}, {24'h0, e_op2});
            end
            if (bus.done || bus.illegal) begin
                hit = n; saw_done = bus.done; saw_ill = bus.illegal;
                break;
            end
            check("busy_ready", {31'h0, bus.instr_ready}, 32'h0);
            glitch     = legal && (n < w);
            glitch_val = 8'($urandom);
        end
        glitch = 1'b0;
        check("latency", hit, legal ? 32'(1 + w) : 32'h1);
        check("done", {31'h0, saw_done}, {31'h0, legal});
        check("illegal", {31'h0, saw_ill}, {31'h0, ~legal});
        m_op1 = e_op1; m_op2 = e_op2; m_aluop = e_aluop;
        if (legal) begin
            m_reg[d] = res;
            m_zf     = (res == 8'h00);
        end
        check("zero_flag", {31'h0, bus.zero_flag}, {31'h0, m_zf});
        check("ready_after", {31'h0, bus.instr_ready}, 32'h1);
        bus.dbg_addr = d;
        #1;
        check("dest_reg", {24'h0, bus.dbg_data}, {24'h0, m_reg[d]});
    endtask

    task automatic run(input logic [31:0] instr);
        accept(instr, 1'b0, 32'h0);
        observe(instr);
    endtask

    initial begin
        logic [31:0] ins;
        logic [7:0]  op;
        reset = 1'b1; bus.instr_valid = 1'b0; bus.instruction = 32'h0; bus.dbg_addr = 3'd0;
        glitch = 1'b0; glitch_val = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("ready_in_reset", {31'h0, bus.instr_ready}, 32'h0);
        reset = 1'b0;
        #1;
        check("rst_ready", {31'h0, bus.instr_ready}, 32'h1);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_illegal", {31'h0, bus.illegal}, 32'h0);
        check("rst_zero_flag", {31'h0, bus.zero_flag}, 32'h0);
        check("rst_operands", {13'h0, bus.aluop, bus.operand1, bus.operand2}, 32'h0);
        sweep("rst_sweep");

        run(32'h00_01_00_05);   // loadi r1,5
        run(32'h00_02_00_03);   // loadi r2,3
        run(32'h02_03_01_02);   // add r3=r1+r2
        run(32'h03_04_02_01);   // sub r4=r2-r1
        run(32'h03_05_01_01);   // sub r5=r1-r1

        // mult with valid held high; the illegal op queued behind it is taken in the DONE cycle
        accept(32'h06_06_01_02, 1'b1, 32'hFF_01_00_00);
        observe(32'h06_06_01_02);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        observe(32'hFF_01_00_00);
        sweep("directed_sweep");

        // reset during WAIT of add r7 abandons the writeback
        accept(32'h02_07_01_02, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        check("rst_wait_aluop", {29'h0, bus.aluop}, 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wait_done", {31'h0, bus.done}, 32'h0);
        check("rst_wait_ready", {31'h0, bus.instr_ready}, 32'h0);
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_wait_ready_after", {31'h0, bus.instr_ready}, 32'h1);
        check("rst_wait_zero_flag", {31'h0, bus.zero_flag}, 32'h0);
        check("rst_wait_operands", {13'h0, bus.aluop, bus.operand1, bus.operand2}, 32'h0);
        sweep("rst_wait_sweep");

        for (int t = 0; t < 120; t++) begin
            op = 8'($urandom_range(0, 10));
            if (op > 8'd8) op = 8'($urandom_range(9, 255));
            ins = {op, 24'($urandom)};
            run(ins);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        sweep("final_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
